ahb_slave_port_mux: RTL
=======================

# ahb_slave_port_mux

Per-slave AHB port multiplexer, one instance per slave, directly downstream of the interconnect's round-robin arbiter. It consumes that slave's one-hot grant and request vectors and drives the granted master's address phase onto the slave. It tracks which master owns the current data phase and routes write data and responses between that master and the slave. If the arbiter moves the grant away from a data-phase owner that has already issued its next transfer, the block defers that transfer in a one-entry buffer so it is not lost.

## Interface
- NO_OF_MASTERS, 4, number of masters (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- ID_W, $clog2(NO_OF_MASTERS), master index width

Ports:
- hclk  in  1  bus clock
- hreset  in  1  asynchronous, active-high reset
- grant  in  NO_OF_MASTERS  one-hot grant for this slave from arbiter (lowest set bit wins if >1)
- req  in  NO_OF_MASTERS  address-decode request vector for this slave
- m_haddr  in  NO_OF_MASTERS*ADDR_WIDTH  packed master addresses
- m_htrans  in  NO_OF_MASTERS*2  master htrans
- m_hwrite / m_hmastlock  in  NO_OF_MASTERS each  master hwrite / hmastlock
- m_hsize / m_hburst  in  NO_OF_MASTERS*3 each  master hsize / hburst
- m_hprot  in  NO_OF_MASTERS*4  master hprot
- m_hwdata  in  NO_OF_MASTERS*DATA_WIDTH  master write data
- m_hready  out  NO_OF_MASTERS  per-master ready; system ANDs this across slave ports
- m_hresp  out  NO_OF_MASTERS  per-master response
- m_hrdata  out  DATA_WIDTH  read data, broadcast
- s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock  out  matching widths  slave address phase
- s_hwdata  out  DATA_WIDTH  slave write data
- s_hreadyin  out  1  hready to slave
- s_hreadyout, s_hresp  in  1 each  slave ready / response
- s_hrdata  in  DATA_WIDTH  slave read data
- data_owner  out  ID_W  current data-phase master
- data_active, defer_active  out  1 each  state is DATA / DEFER

## Operation
- States: IDLE (no data phase), DATA (data phase of `data_owner`), DEFER (buffered transfer of `def_m` awaiting issue).
- Valid transfer: htrans[1]=1 (NONSEQ/SEQ).
- Address source:
  - In IDLE or DATA: the granted master g. `s_hsel`=1 when any grant bit is set; all other fields come from g.
  - In DEFER: the buffer. `s_hsel`=1 and `s_htrans` is the buffered value.
  - No grant and not in DEFER: all address-phase outputs are 0.
- s_hreadyin: 1 in IDLE and DEFER; `s_hreadyout` in DATA.
- Accept: a valid transfer is accepted when `s_hsel`=1 and `s_hreadyin`=1.
  - Next state DATA; owner = g, or `def_m` when accepted from DEFER.
- DATA ends when `s_hreadyout`=1 and nothing is accepted. Next state is IDLE, unless the defer condition holds.
- Defer condition: in DATA, `s_hreadyout`=1, owner shows a valid transfer, `req[owner]`=1 and `grant[owner]`=0.
  - Capture the owner's address and control into the buffer; `def_m` = owner; next state DEFER.
  - The deferred address takes priority over `grant`.
- m_hready[i], first match applies:
  - DEFER and i=def_m: 0.
  - DATA and i=owner: `s_hreadyout`.
  - i=g: `s_hreadyin` (0 in DEFER).
  - req[i] and valid transfer, not granted: 0.
  - Otherwise: 1.
- m_hresp[owner]: `s_hresp` in DATA; 0 for every other master and in every other state. A two-cycle ERROR passes through unchanged.
- s_hwdata: m_hwdata[owner] in DATA, else 0. The deferred master holds hwdata because it sees hready low.
- m_hrdata = s_hrdata at all times.

## Timing
- Address-phase path is combinational: grant and master inputs to `s_*` outputs.
- State, owner and buffer are registered on `hclk`.
- Data phase starts the cycle after accept. Added latency is 0 cycles, except 1 extra slave address cycle for a deferred transfer.
- Reset (`hreset`=1, asynchronous) clears state to IDLE, owner 0, buffer 0.
  - While reset is asserted: all `s_*` outputs 0, `s_hreadyin`=1, `m_hready` all 1, `m_hresp` all 0, status outputs 0.
  - Reset mid-DEFER or mid-DATA discards the transfer without a response.
- Grant changes while `s_hreadyin`=0 have no effect until ready; the new grantee sees hready 0.
- Simultaneous end of data phase and new grantee accept: state stays DATA; owner switches in the same edge.

## Test plan
- Single write: grant=0001, M0 NONSEQ write 0x100, s_hreadyout=1 → next cycle data_active=1, data_owner=0, s_hwdata=M0 data; following cycle IDLE.
- Wait states: M0 in DATA, s_hreadyout=0 for 2 cycles, M1 req=1 ungranted → m_hready[0]=0 and m_hready[1]=0 for 2 cycles; M0 completes on cycle 3.
- Handoff: M0 last data cycle, grant=0010, M1 NONSEQ 0x200 → next edge data_owner=1, s_hwdata=M1 data, no idle cycle.
- Defer: owner M0 shows NONSEQ 0x300 with grant=0010, s_hreadyout=1 → defer_active=1, s_haddr=0x300, m_hready[0]=0, m_hready[1]=0; next edge DATA, owner 0.
- Error: s_hresp=1 with s_hreadyout=0 then 1 → m_hresp[owner] high 2 cycles, all other m_hresp=0.
- Reset in DEFER: hreset pulse → immediately s_hsel=0, all m_hready=1, defer_active=0; IDLE after release.

Source files
------------

// File: rtl/ahb_slave_port_mux.sv
// Per-slave AHB port multiplexer: routes the granted master's address phase to the slave,
// tracks the data-phase owner, and parks a stranded next transfer in a one-entry defer buffer.
module ahb_slave_port_mux #(
    parameter int NO_OF_MASTERS = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_W          = $clog2(NO_OF_MASTERS)
) (
    input  logic                               hclk,
    input  logic                               hreset,
    input  logic [NO_OF_MASTERS-1:0]           grant,
    input  logic [NO_OF_MASTERS-1:0]           req,
    input  logic [NO_OF_MASTERS*ADDR_WIDTH-1:0] m_haddr,
    input  logic [NO_OF_MASTERS*2-1:0]         m_htrans,
    input  logic [NO_OF_MASTERS-1:0]           m_hwrite,
    input  logic [NO_OF_MASTERS-1:0]           m_hmastlock,
    input  logic [NO_OF_MASTERS*3-1:0]         m_hsize,
    input  logic [NO_OF_MASTERS*3-1:0]         m_hburst,
    input  logic [NO_OF_MASTERS*4-1:0]         m_hprot,
    input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0] m_hwdata,
    output logic [NO_OF_MASTERS-1:0]           m_hready,
    output logic [NO_OF_MASTERS-1:0]           m_hresp,
    output logic [DATA_WIDTH-1:0]              m_hrdata,
    output logic                               s_hsel,
    output logic [ADDR_WIDTH-1:0]              s_haddr,
    output logic [1:0]                         s_htrans,
    output logic                               s_hwrite,
    output logic [2:0]                         s_hsize,
    output logic [2:0]                         s_hburst,
    output logic [3:0]                         s_hprot,
    output logic                               s_hmastlock,
    output logic [DATA_WIDTH-1:0]              s_hwdata,
    output logic                               s_hreadyin,
    input  logic                               s_hreadyout,
    input  logic                               s_hresp,
    input  logic [DATA_WIDTH-1:0]              s_hrdata,
    output logic [ID_W-1:0]                    data_owner,
    output logic                               data_active,
    output logic                               defer_active
);

    // Handshake: an address phase is taken by the slave on a clock edge where
    // s_hsel & s_htrans[1] & s_hreadyin are all high; a data phase completes on
    // an edge where s_hreadyout is high. A master advances only when its m_hready is high.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DEFER = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         owner_q, owner_d;
    logic [ID_W-1:0]         def_m_q, def_m_d;
    logic [ADDR_WIDTH-1:0]   buf_addr_q, buf_addr_d;
    logic [1:0]              buf_trans_q, buf_trans_d;
    logic                    buf_write_q, buf_write_d;
    logic [2:0]              buf_size_q, buf_size_d;
    logic [2:0]              buf_burst_q, buf_burst_d;
    logic [3:0]              buf_prot_q, buf_prot_d;
    logic                    buf_lock_q, buf_lock_d;

    logic [ADDR_WIDTH-1:0]   mst_addr  [NO_OF_MASTERS];
    logic [1:0]              mst_trans [NO_OF_MASTERS];
    logic [2:0]              mst_size  [NO_OF_MASTERS];
    logic [2:0]              mst_burst [NO_OF_MASTERS];
    logic [3:0]              mst_prot  [NO_OF_MASTERS];
    logic [DATA_WIDTH-1:0]   mst_wdata [NO_OF_MASTERS];

    logic [ID_W-1:0]         g_idx;
    logic                    g_any;
    logic                    accept;
    logic                    defer_cond;

    genvar gi;
    generate
        for (gi = 0; gi < NO_OF_MASTERS; gi++) begin : g_unpack
            assign mst_addr[gi]  = m_haddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign mst_trans[gi] = m_htrans[gi*2 +: 2];
            assign mst_size[gi]  = m_hsize[gi*3 +: 3];
            assign mst_burst[gi] = m_hburst[gi*3 +: 3];
            assign mst_prot[gi]  = m_hprot[gi*4 +: 4];
            assign mst_wdata[gi] = m_hwdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Descending scan so the lowest set grant bit wins if the arbiter ever glitches multi-hot.
    always_comb begin
        g_idx = '0;
        g_any = 1'b0;
        for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
            if (grant[i]) begin
                g_idx = ID_W'(i);
                g_any = 1'b1;
            end
        end
    end

    always_comb begin
        s_hsel      = 1'b0;
        s_haddr     = '0;
        s_htrans    = 2'b00;
        s_hwrite    = 1'b0;
        s_hsize     = 3'b000;
        s_hburst    = 3'b000;
        s_hprot     = 4'b0000;
        s_hmastlock = 1'b0;
        if (!hreset) begin
            if (state_q == ST_DEFER) begin
                s_hsel      = 1'b1;
                s_haddr     = buf_addr_q;
                s_htrans    = buf_trans_q;
                s_hwrite    = buf_write_q;
                s_hsize     = buf_size_q;
                s_hburst    = buf_burst_q;
                s_hprot     = buf_prot_q;
                s_hmastlock = buf_lock_q;
            end else if (g_any) begin
                s_hsel      = 1'b1;
                s_haddr     = mst_addr[g_idx];
                s_htrans    = mst_trans[g_idx];
                s_hwrite    = m_hwrite[g_idx];
                s_hsize     = mst_size[g_idx];
                s_hburst    = mst_burst[g_idx];
                s_hprot     = mst_prot[g_idx];
                s_hmastlock = m_hmastlock[g_idx];
            end
        end
    end

    assign s_hreadyin = (state_q == ST_DATA) ? s_hreadyout : 1'b1;
    assign accept     = s_hsel & s_htrans[1] & s_hreadyin;

    // Owner already sampled hready high and moved on, but lost the grant: its next transfer would vanish.
    assign defer_cond = (state_q == ST_DATA) && s_hreadyout && mst_trans[owner_q][1]
                        && req[owner_q] && !grant[owner_q];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        def_m_d     = def_m_q;
        buf_addr_d  = buf_addr_q;
        buf_trans_d = buf_trans_q;
        buf_write_d = buf_write_q;
        buf_size_d  = buf_size_q;
        buf_burst_d = buf_burst_q;
        buf_prot_d  = buf_prot_q;
        buf_lock_d  = buf_lock_q;
        if (accept) begin
            state_d = ST_DATA;
            owner_d = (state_q == ST_DEFER) ? def_m_q : g_idx;
        end else if (state_q == ST_DATA && s_hreadyout) begin
            if (defer_cond) begin
                state_d     = ST_DEFER;
                def_m_d     = owner_q;
                buf_addr_d  = mst_addr[owner_q];
                buf_trans_d = mst_trans[owner_q];
                buf_write_d = m_hwrite[owner_q];
                buf_size_d  = mst_size[owner_q];
                buf_burst_d = mst_burst[owner_q];
                buf_prot_d  = mst_prot[owner_q];
                buf_lock_d  = m_hmastlock[owner_q];
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        m_hready = '1;
        m_hresp  = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (state_q == ST_DATA && owner_q == ID_W'(i)) begin
                m_hresp[i] = s_hresp;
            end
            if (hreset) begin
                m_hready[i] = 1'b1;
            end else if (state_q == ST_DEFER && def_m_q == ID_W'(i)) begin
                m_hready[i] = 1'b0;
            end else if (state_q == ST_DATA && owner_q == ID_W'(i)) begin
                m_hready[i] = s_hreadyout;
            end else if (g_any && g_idx == ID_W'(i)) begin
                m_hready[i] = (state_q == ST_DEFER) ? 1'b0 : s_hreadyin;
            end else if (req[i] && mst_trans[i][1]) begin
                m_hready[i] = 1'b0;
            end else begin
                m_hready[i] = 1'b1;
            end
        end
    end

    assign s_hwdata     = (state_q == ST_DATA) ? mst_wdata[owner_q] : '0;
    assign m_hrdata     = s_hrdata;
    assign data_owner   = owner_q;
    assign data_active  = (state_q == ST_DATA);
    assign defer_active = (state_q == ST_DEFER);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            def_m_q     <= '0;
            buf_addr_q  <= '0;
            buf_trans_q <= 2'b00;
            buf_write_q <= 1'b0;
            buf_size_q  <= 3'b000;
            buf_burst_q <= 3'b000;
            buf_prot_q  <= 4'b0000;
            buf_lock_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            def_m_q     <= def_m_d;
            buf_addr_q  <= buf_addr_d;
            buf_trans_q <= buf_trans_d;
            buf_write_q <= buf_write_d;
            buf_size_q  <= buf_size_d;
            buf_burst_q <= buf_burst_d;
            buf_prot_q  <= buf_prot_d;
            buf_lock_q  <= buf_lock_d;
        end
    end

endmodule
